// File: rtl/encoder_sim.sv
// ---------------------------------------------------------------------------
// encoder_sim
//   Closed-loop plant model for the motor speed controller. It measures the
//   duty cycle of the controller's PWM over fixed windows, turns duty into a
//   simulated shaft speed through a first-order lag, and emits encoder edges
//   at that speed (one channel-A rising edge per degree).
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   pwm_in       in   controller PWM (asynchronous, synchronised here)
//   enc_a        out  encoder channel A
//   enc_b        out  encoder channel B (0 unless quadrature is enabled)
//   speed_deg_s  out  simulated speed in deg/s, unsigned
//   window_done  out  1-cycle strobe, high while speed_deg_s shows a new value
//
// Build option
//   ENCODER_SIM_QUAD_EN : quadrature output; (enc_a,enc_b) walk the Gray
//                         sequence 00->10->11->01, four edges per degree.
//                         Undefined: A toggles twice per degree, B tied 0.
// ---------------------------------------------------------------------------
module encoder_sim #(
   parameter int unsigned CLK_HZ     = 16000000,
   parameter int unsigned WINDOW_LOG = 10,
   parameter int unsigned MAX_DEG_S  = 1440,
   parameter int unsigned LAG_LOG    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pwm_in,
   output logic        enc_a,
   output logic        enc_b,
   output logic [15:0] speed_deg_s,
   output logic        window_done
);

`ifdef ENCODER_SIM_QUAD_EN
   localparam int unsigned EDGES = 4;
`else
   localparam int unsigned EDGES = 2;
`endif

   localparam int unsigned HC_W   = WINDOW_LOG + 1;
   localparam int unsigned PROD_W = HC_W + 16;
   localparam logic [31:0] C_HZ   = 32'(CLK_HZ);

   typedef enum logic {S_MEASURE, S_UPDATE} state_t;

   // ---------------- input synchroniser ----------------
   logic [1:0] r_sync;
   logic       w_pwm_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_sync <= 2'b00;
      else       r_sync <= {r_sync[0], pwm_in};
   end

   assign w_pwm_s = r_sync[1];

   // ---------------- measurement FSM ----------------
   state_t                r_state, w_state_nxt;
   logic                  w_upd;
   logic [WINDOW_LOG-1:0] r_win_cnt;
   logic [HC_W-1:0]       r_high_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_MEASURE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_upd       = 1'b0;
      case (r_state)
         // the sample taken in the last counted cycle is still included
         S_MEASURE: if (r_win_cnt == '1) w_state_nxt = S_UPDATE;
         S_UPDATE: begin
            w_upd       = 1'b1;
            w_state_nxt = S_MEASURE;
         end
         default: w_state_nxt = S_MEASURE;
      endcase
   end

   // no sample is taken in the update cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_win_cnt  <= '0;
         r_high_cnt <= '0;
      end else if (w_upd) begin
         r_win_cnt  <= '0;
         r_high_cnt <= '0;
      end else begin
         r_win_cnt  <= r_win_cnt + 1'b1;
         r_high_cnt <= r_high_cnt + HC_W'(w_pwm_s);
      end
   end

   // ---------------- speed filter ----------------
   logic [PROD_W-1:0]  w_prod;
   logic [15:0]        w_target;
   logic signed [16:0] w_diff;
   logic signed [16:0] w_shift;
   logic signed [16:0] w_step;
   logic [15:0]        r_speed;
   logic               r_window_done;

   assign w_prod   = PROD_W'(r_high_cnt) * PROD_W'(MAX_DEG_S);
   assign w_target = 16'(w_prod >> WINDOW_LOG);
   assign w_diff   = $signed({1'b0, w_target}) - $signed({1'b0, r_speed});
   assign w_shift  = w_diff >>> LAG_LOG;

   // once the remaining error shifts to zero, creep by one so the filter
   // lands exactly on target instead of stalling short of it
   always_comb begin
      w_step = w_shift;
      if (w_shift == 17'sd0 && w_diff != 17'sd0)
         w_step = w_diff[16] ? -17'sd1 : 17'sd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_speed       <= '0;
         r_window_done <= 1'b0;
      end else begin
         r_window_done <= w_upd;
         if (w_upd) r_speed <= r_speed + w_step[15:0];
      end
   end

   assign speed_deg_s = r_speed;
   assign window_done = r_window_done;

   // ---------------- pulse generator ----------------
   // Phase accumulator with modulus CLK_HZ. Parameter limits keep the
   // increment below CLK_HZ/2, so at most one edge fires per clock. At zero
   // speed the accumulator simply holds, freezing the outputs in place.
   logic [31:0] r_acc;
   logic [31:0] w_sum;
   logic        w_edge;

   assign w_sum  = r_acc + 32'(r_speed) * 32'(EDGES);
   assign w_edge = (w_sum >= C_HZ);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_acc <= '0;
      else if (w_edge) r_acc <= w_sum - C_HZ;
      else             r_acc <= w_sum;
   end

`ifdef ENCODER_SIM_QUAD_EN
   // {A,B}: next = {~B, A} walks 00->10->11->01->00, A leading B
   logic [1:0] r_gray;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_gray <= 2'b00;
      else if (w_edge) r_gray <= {~r_gray[0], r_gray[1]};
   end

   assign enc_a = r_gray[1];
   assign enc_b = r_gray[0];
`else
   logic r_enc_a;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_enc_a <= 1'b0;
      else if (w_edge) r_enc_a <= ~r_enc_a;
   end

   assign enc_a = r_enc_a;
   assign enc_b = 1'b0;
`endif

endmodule

// File: tb/tb_encoder_sim.sv
// ---------------------------------------------------------------------------
// tb_encoder_sim
//   Two instances share clock, reset and PWM: index 0 with LAG_LOG=2, index 1
//   with LAG_LOG=0. Clock and window are scaled down (CLK_HZ=20000, 64-clock
//   windows) so one simulated second is 20000 cycles.
// ---------------------------------------------------------------------------
module tb_encoder_sim;
   localparam int CLKHZ = 20000;
   localparam int WL    = 6;
   localparam int MAXD  = 1440;
   localparam int WIN   = (1 << WL) + 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pwm = 1'b0;
   logic        ea [2];
   logic        eb [2];
   logic        wd [2];
   logic [15:0] spd [2];

   encoder_sim #(.CLK_HZ(CLKHZ), .WINDOW_LOG(WL), .MAX_DEG_S(MAXD), .LAG_LOG(2)) u_lag2 (
      .clk(clk), .reset(rst), .pwm_in(pwm), .enc_a(ea[0]), .enc_b(eb[0]),
      .speed_deg_s(spd[0]), .window_done(wd[0]));

   encoder_sim #(.CLK_HZ(CLKHZ), .WINDOW_LOG(WL), .MAX_DEG_S(MAXD), .LAG_LOG(0)) u_lag0 (
      .clk(clk), .reset(rst), .pwm_in(pwm), .enc_a(ea[1]), .enc_b(eb[1]),
      .speed_deg_s(spd[1]), .window_done(wd[1]));

   always #5 clk = ~clk;

   typedef struct {int spd; int cyc;} exp_t;
   typedef struct {int duty; int nwin; int exp2; int exp0;} vec_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc, pcnt, duty, m_high;
   int   m_spd [2];
   int   n_done [2];
   int   last_chg [2];
   bit   pa [2];
   bit   pb [2];
   bit   h1, h2, h3;
   bit   meas;
   int   ra, rb, last_rise, sp_min, sp_max, b_bad;

   task automatic chk(string name, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_rng(string name, int act, int lo, int hi);
      n_vec++;
      if (act < lo || act > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
      end
   endtask

   // filter reference: target from the high count, then a lagged step
   function automatic int nxt(int s, int high, int lag);
      int t, d, st;
      t  = (high * MAXD) >> WL;
      d  = t - s;
      st = d >>> lag;
      if (st == 0 && d != 0) st = (d > 0) ? 1 : -1;
      return s + st;
   endfunction

   task automatic sb(int i);
      exp_t e;
      n_done[i]++;
      if (i == 0) begin
         if (q0.size() == 0) begin chk("unexpected_done_lag2", 1, 0); return; end
         e = q0.pop_front();
      end else begin
         if (q1.size() == 0) begin chk("unexpected_done_lag0", 1, 0); return; end
         e = q1.pop_front();
      end
      chk(i == 0 ? "speed_lag2" : "speed_lag0", int'(spd[i]), e.spd);
      chk(i == 0 ? "done_cycle_lag2" : "done_cycle_lag0", cyc, e.cyc);
   endtask

   // one clock: check strobes, advance the reference, monitor encoders,
   // drive the next PWM sample
   task automatic tick();
      exp_t e;
      @(posedge clk); #1;
      if (rst) return;
      cyc++;
      for (int i = 0; i < 2; i++) if (wd[i]) sb(i);
      // edge cyc counts the PWM value driven three ticks ago
      if ((cyc - 1) % WIN < WIN - 1) m_high += int'(h3);
      if ((cyc - 1) % WIN == WIN - 2) begin
         for (int i = 0; i < 2; i++) begin
            m_spd[i] = nxt(m_spd[i], m_high, (i == 0) ? 2 : 0);
            e.spd = m_spd[i];
            e.cyc = cyc + 1;
            if (i == 0) q0.push_back(e); else q1.push_back(e);
         end
         m_high = 0;
      end
      for (int i = 0; i < 2; i++) begin
         if (ea[i] != pa[i] || eb[i] != pb[i]) begin
            last_chg[i] = cyc;
`ifdef ENCODER_SIM_QUAD_EN
            if ({ea[i], eb[i]} != {~pb[i], pa[i]}) b_bad++;
`endif
         end
`ifndef ENCODER_SIM_QUAD_EN
         if (eb[i]) b_bad++;
`endif
      end
      if (meas) begin
         if (ea[1] && !pa[1]) begin
            ra++;
            if (last_rise >= 0) begin
               if (cyc - last_rise < sp_min) sp_min = cyc - last_rise;
               if (cyc - last_rise > sp_max) sp_max = cyc - last_rise;
            end
            last_rise = cyc;
         end
         if (eb[1] && !pb[1]) rb++;
      end
      for (int i = 0; i < 2; i++) begin pa[i] = ea[i]; pb[i] = eb[i]; end
      pcnt++;
      pwm = ((pcnt % 16) < duty);
      h3 = h2; h2 = h1; h1 = pwm;
   endtask

   task automatic do_release();
      @(posedge clk); #1;
      rst = 1'b0;
      cyc = 0; pcnt = 0; m_high = 0;
      q0.delete(); q1.delete();
      for (int i = 0; i < 2; i++) begin
         m_spd[i] = 0; n_done[i] = 0; last_chg[i] = 0; pa[i] = 0; pb[i] = 0;
      end
      pwm = (0 < duty);
      h1 = pwm; h2 = 1'b0; h3 = 1'b0;
   endtask

   initial begin
      vec_t tbl [5];
      int   zbad;
      tbl[0] = '{4,  28, 360,  360};
      tbl[1] = '{0,  35, 0,    0};
      tbl[2] = '{16, 40, 1440, 1440};
      tbl[3] = '{8,  40, 720,  720};
      tbl[4] = '{1,  40, 90,   90};
      cyc = 0; duty = 0; meas = 0; b_bad = 0; zbad = 0;

      // reset held with a busy PWM: everything stays at zero
      repeat (500) begin
         @(posedge clk); #1;
         pwm = 1'($urandom);
         if (ea[0] || ea[1] || eb[0] || eb[1] || wd[0] || wd[1] ||
             spd[0] != 0 || spd[1] != 0) zbad++;
      end
      chk("reset_hold_outputs", zbad, 0);
      chk("reset_speed", int'(spd[0]), 0);
      chk("reset_enc_a", int'(ea[0]), 0);

      duty = tbl[0].duty;
      do_release();
      for (int k = 0; k < 5; k++) begin
         duty = tbl[k].duty;
         // odd tick count so later duty changes land mid-window
         repeat (tbl[k].nwin * WIN + 17) tick();
         chk($sformatf("final_lag2_duty%0d", tbl[k].duty), int'(spd[0]), tbl[k].exp2);
         chk($sformatf("final_lag0_duty%0d", tbl[k].duty), int'(spd[1]), tbl[k].exp0);
         if (tbl[k].duty == 0) begin
            chk_rng("hold_enc_lag2", cyc - last_chg[0], 10 * WIN, 1 << 30);
            chk_rng("hold_enc_lag0", cyc - last_chg[1], 10 * WIN, 1 << 30);
         end
         if (tbl[k].duty == 16) begin
            // one simulated second at 1440 deg/s
            meas = 1; ra = 0; rb = 0; last_rise = -1; sp_min = 1 << 30; sp_max = 0;
            repeat (CLKHZ) tick();
            meas = 0;
            chk_rng("a_rises_per_s", ra, 1439, 1441);
            chk_rng("a_spacing_min", sp_min, 13, 14);
            chk_rng("a_spacing_max", sp_max, 13, 14);
`ifdef ENCODER_SIM_QUAD_EN
            chk_rng("b_rises_per_s", rb, 1439, 1441);
`else
            chk("b_rises_per_s", rb, 0);
`endif
         end
      end

      // reset pulse mid-window: immediate clear, then a fresh full window
      repeat (30) tick();
      rst = 1'b1;
      #1;
      chk("midrst_speed_lag2", int'(spd[0]), 0);
      chk("midrst_speed_lag0", int'(spd[1]), 0);
      chk("midrst_enc_a", int'(ea[0]) + int'(ea[1]), 0);
      chk("midrst_done", int'(wd[0]) + int'(wd[1]), 0);
      duty = 16;
      do_release();
      repeat (3 * WIN + 5) tick();
      chk("post_reset_windows", n_done[0], 3);
      chk("enc_b_behaviour", b_bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
